lsu_master: RTL and testbench

LSU_MASTER -- requirements
Module: lsu_master

---
 rtl/lsu_master.sv | 163 ++++++++++++++++
 tb/tb_lsu_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_master.sv
// Load/store unit memory master: takes one M-stage access at a time, checks alignment,
// issues a word-wide memory request and returns lane-extracted, extended load data.
module lsu_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  req_cnt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_sign;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        misaligned;
    logic        accept;
    logic        timed_out;
    logic [31:0] lane_data;
    logic [31:0] load_data;

    // Size 11 has no legal alignment, so it is rejected like any misaligned access.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign accept    = (state == IDLE) && req_valid && !misaligned;
    assign timed_out = (state == REQ) && !mem_ack && (req_cnt == 8'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An ack in the final allowed cycle still completes normally; timeout only fires without one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = REQ;
            REQ: begin
                if (mem_ack) begin
                    state_next = RESP;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE:    req_ready  = 1'b1;
            REQ:     mem_req    = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: req_ready  = 1'b0;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend to the access width.
    always_comb begin
        lane_data = mem_rdata >> {lat_addr[1:0], 3'b000};
        load_data = lane_data;
        case (lat_size)
            2'b00:   load_data = {{24{lat_sign & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_data = {{16{lat_sign & lane_data[15]}}, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_cnt    <= 8'd0;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_sign   <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            addr_err   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            addr_err <= (state == IDLE) && req_valid && misaligned;
            bus_err  <= timed_out;
            if (accept) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_sign  <= req_sign;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                req_cnt   <= 8'd1;
            end else if (state == REQ) begin
                req_cnt <= req_cnt + 8'd1;
            end
            if ((state == REQ) && mem_ack) begin
                resp_rdata <= lat_we ? 32'd0 : load_data;
            end
        end
    end

    assign mem_we   = lat_we;
    assign mem_addr = {lat_addr[31:2], 2'b00};

    // Narrow stores are replicated across all lanes; the byte enables pick the live one.
    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = lat_wdata;
        case (lat_size)
            2'b00: begin
                mem_be    = 4'b0001 << lat_addr[1:0];
                mem_wdata = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                mem_be    = 4'b0011 << lat_addr[1:0];
                mem_wdata = {2{lat_wdata[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = lat_wdata;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_master.sv
// Self-checking bench for lsu_master: directed corner cases followed by random accesses,
// all compared against an arithmetic reference model of the access rules.
module tb_lsu_master;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: access width in bytes and byte offset drive everything.
    function automatic int modelBytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic bit modelMisaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        return (int'(addr[1:0]) % modelBytes(size)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [31:0] addr);
        int nb = modelBytes(size);
        int off = int'(addr[1:0]);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        int nb = modelBytes(size);
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(wdata >> (8 * (i % nb)));
        return r;
    endfunction

    function automatic logic [31:0] modelRdata(input logic we, input logic [1:0] size, input logic sign,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        int nb = modelBytes(size);
        int off = int'(addr[1:0]);
        logic [63:0] mask;
        logic [63:0] v;
        if (we) return 32'd0;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = 64'(rdata >> (8 * off)) & mask;
        if (sign && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sign,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Starts and ends at a negedge with the DUT idle; ack is raised in REQ cycle ackDelay.
    task automatic doAccess(input logic we, input logic [1:0] size, input logic sign, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int ackDelay);
        logic [31:0] expRdata;
        expRdata = modelRdata(we, size, sign, addr, rdata);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        applyStimulus(we, size, sign, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= ackDelay; n++) begin
            checkOutput("mem_req_held", 32'(mem_req), 32'd1);
            if (n == 1) begin
                checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
                checkOutput("mem_be", 32'(mem_be), 32'(modelBe(size, addr)));
                checkOutput("mem_we", 32'(mem_we), 32'(we));
                if (we) checkOutput("mem_wdata", mem_wdata, modelWdata(size, wdata));
            end
            mem_ack   = (n == ackDelay);
            mem_rdata = (n == ackDelay) ? rdata : $urandom;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checkOutput("resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("resp_rdata", resp_rdata, expRdata);
        checkOutput("bus_err_ok", 32'(bus_err), 32'd0);
        checkOutput("mem_req_resp", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("resp_valid_pulse", 32'(resp_valid), 32'd0);
        checkOutput("resp_rdata_hold", resp_rdata, expRdata);
    endtask

    task automatic checkMisaligned(input logic we, input logic [1:0] size, input logic [31:0] addr);
        applyStimulus(we, size, 1'b0, addr, 32'hDEADBEEF);
        mem_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        checkOutput("addr_err", 32'(addr_err), 32'd1);
        checkOutput("misaligned_no_req", 32'(mem_req), 32'd0);
        checkOutput("misaligned_ready", 32'(req_ready), 32'd1);
        checkOutput("misaligned_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        checkOutput("addr_err_pulse", 32'(addr_err), 32'd0);
        checkOutput("misaligned_no_req2", 32'(mem_req), 32'd0);
    endtask

    initial begin
        int reqCycles;
        int busErrs;
        int resps;
        logic        rWe;
        logic [1:0]  rSize;
        logic        rSign;
        logic [31:0] rAddr;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
        checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] directed accesses");
        doAccess(1'b0, 2'b00, 1'b1, 32'h00000003, 32'd0, 32'h80FF1234, 1);
        doAccess(1'b1, 2'b01, 1'b0, 32'h00000102, 32'h0000ABCD, 32'h12345678, 2);
        doAccess(1'b0, 2'b01, 1'b0, 32'h00000002, 32'd0, 32'hF00D0000, 1);
        checkMisaligned(1'b0, 2'b10, 32'h00000006);
        checkMisaligned(1'b1, 2'b11, 32'h00000000);
        checkMisaligned(1'b0, 2'b01, 32'h00000011);

        $display("[TB] timeout without ack");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00000040, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reqCycles = 0;
        busErrs   = 0;
        resps     = 0;
        for (int n = 0; n < TIMEOUT + 4; n++) begin
            reqCycles += int'(mem_req);
            busErrs   += int'(bus_err);
            resps     += int'(resp_valid);
            @(negedge clk);
        end
        checkOutput("timeout_req_cycles", 32'(reqCycles), 32'(TIMEOUT));
        checkOutput("timeout_bus_err", 32'(busErrs), 32'd1);
        checkOutput("timeout_no_resp", 32'(resps), 32'd0);
        doAccess(1'b0, 2'b10, 1'b0, 32'h00000044, 32'd0, 32'hCAFEF00D, TIMEOUT);

        $display("[TB] reset during access");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00000200, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abort_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        checkOutput("abort_req_drop", 32'(mem_req), 32'd0);
        checkOutput("abort_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("abort_late_ack", 32'(resp_valid), 32'd0);
        checkOutput("abort_idle_req", 32'(mem_req), 32'd0);
        checkOutput("abort_ready", 32'(req_ready), 32'd1);
        doAccess(1'b0, 2'b00, 1'b0, 32'h00000201, 32'd0, 32'h00AB0000, 1);

        $display("[TB] random accesses");
        for (int i = 0; i < 40; i++) begin
            rWe   = 1'($urandom_range(0, 1));
            rSize = 2'($urandom_range(0, 3));
            rSign = 1'($urandom_range(0, 1));
            rAddr = $urandom;
            if ($urandom_range(0, 1) == 1) rAddr[1:0] = 2'b00;
            if (modelMisaligned(rSize, rAddr)) begin
                checkMisaligned(rWe, rSize, rAddr);
            end else begin
                doAccess(rWe, rSize, rSign, rAddr, $urandom, $urandom, int'($urandom_range(1, 4)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
